mux_serializer: RTL and testbench

- Parallel-to-serial stage that sits directly upstream of the existing mux16to1.
- Accepts a 16-bit word over a valid/ready handshake and holds it in a data register.
- Drives the mux16to1 select from a 4-bit bit-index counter and presents the selected bit as a serial stream with valid/ready/last.
- Reuses the structural mux for bit extraction. The new logic is the sequencing, handshake and back-pressure control.

---
 rtl/mux_serializer_pkg.sv | 26 ++
 rtl/mux16to1.sv | 18 +
 rtl/mux_serializer.sv | 102 ++++++++++
 tb/tb_mux_serializer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module : mux_serializer_pkg
// Brief  : Shared types and index constants for the 16-bit mux serializer.
// Rev    : 1.0  initial release
// ============================================================================
package mux_serializer_pkg;

    localparam int WORD_W = 16;
    localparam int IDX_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] first_idx(input bit msb_first);
        return msb_first ? IDX_W'(WORD_W - 1) : '0;
    endfunction

    function automatic logic [IDX_W-1:0] last_idx(input bit msb_first);
        return msb_first ? '0 : IDX_W'(WORD_W - 1);
    endfunction

endpackage : mux_serializer_pkg
`default_nettype wire

// File: rtl/mux16to1.sv
`default_nettype none
// ============================================================================
// Module : mux16to1
// Brief  : Structural 16:1 bit multiplexer used for serial bit extraction.
// Rev    : 1.0  initial release
// ============================================================================
module mux16to1
    import mux_serializer_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [IDX_W-1:0]  sel,
    output logic              out
);

    assign out = in[sel];

endmodule : mux16to1
`default_nettype wire

// File: rtl/mux_serializer.sv
`default_nettype none
// ============================================================================
// Module : mux_serializer
// Brief  : Valid/ready 16-bit parallel-to-serial stage driving mux16to1.
// Rev    : 1.0  initial release
// ============================================================================
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [IDX_W-1:0] C_FIRST = first_idx(MSB_FIRST);
    localparam logic [IDX_W-1:0] C_LAST  = last_idx(MSB_FIRST);

    state_t             r_state;
    logic [WORD_W-1:0]  r_data;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               r_in_ready;
    logic               r_ser_valid;
    logic               r_ser_last;
    logic               r_busy;
    logic [IDX_W-1:0]   w_idx_next;

    assign w_idx_next = MSB_FIRST ? (r_bit_idx - IDX_W'(1)) : (r_bit_idx + IDX_W'(1));

    // Handshake outputs are registered alongside the state, so neither
    // in_valid nor ser_ready reaches any output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_bit_idx   <= '0;
            r_word_cnt  <= '0;
            r_in_ready  <= 1'b1;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state     <= ST_SHIFT;
                        r_data      <= in_data;
                        r_bit_idx   <= C_FIRST;
                        r_in_ready  <= 1'b0;
                        r_ser_valid <= 1'b1;
                        r_ser_last  <= (C_FIRST == C_LAST);
                        r_busy      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        if (r_bit_idx == C_LAST) begin
                            // bit_idx is left as-is; the next capture reloads it
                            r_state     <= ST_IDLE;
                            r_word_cnt  <= r_word_cnt + CNT_W'(1);
                            r_in_ready  <= 1'b1;
                            r_ser_valid <= 1'b0;
                            r_ser_last  <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_bit_idx  <= w_idx_next;
                            r_ser_last <= (w_idx_next == C_LAST);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mux16to1 u_mux (
        .in  (r_data),
        .sel (r_bit_idx),
        .out (ser_out)
    );

    assign in_ready  = r_in_ready;
    assign ser_valid = r_ser_valid;
    assign ser_last  = r_ser_last;
    assign busy      = r_busy;
    assign word_cnt  = r_word_cnt;

endmodule : mux_serializer
`default_nettype wire

// File: tb/tb_mux_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_mux_serializer
// Brief  : Directed self-checking bench; LSB-first and MSB-first instances
//          share one stimulus stream and are checked against each word.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mux_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        ser_ready;

    logic        l_in_ready, l_ser_out, l_ser_valid, l_ser_last, l_busy;
    logic [7:0]  l_word_cnt;
    logic        m_in_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
    logic [7:0]  m_word_cnt;

    int          n_cmp;
    int          n_err;
    logic [7:0]  exp_cnt;

    mux_serializer #(.MSB_FIRST(1'b0), .CNT_W(8)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .in_data   (in_data),
        .ser_out   (l_ser_out),
        .ser_valid (l_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (l_ser_last),
        .busy      (l_busy),
        .word_cnt  (l_word_cnt)
    );

    mux_serializer #(.MSB_FIRST(1'b1), .CNT_W(8)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .in_data   (in_data),
        .ser_out   (m_ser_out),
        .ser_valid (m_ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (m_ser_last),
        .busy      (m_busy),
        .word_cnt  (m_word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " l_in_ready"},  32'(l_in_ready),  32'd1);
        chk({tag, " m_in_ready"},  32'(m_in_ready),  32'd1);
        chk({tag, " l_ser_valid"}, 32'(l_ser_valid), 32'd0);
        chk({tag, " m_ser_valid"}, 32'(m_ser_valid), 32'd0);
        chk({tag, " l_busy"},      32'(l_busy),      32'd0);
        chk({tag, " m_busy"},      32'(m_busy),      32'd0);
        chk({tag, " l_ser_last"},  32'(l_ser_last),  32'd0);
        chk({tag, " l_word_cnt"},  32'(l_word_cnt),  32'(exp_cnt));
        chk({tag, " m_word_cnt"},  32'(m_word_cnt),  32'(exp_cnt));
    endtask

    // Called at a negedge with both DUTs idle. bp selects the 1,0,0 ready
    // pattern; hold keeps in_valid high with nxt on in_data during the word.
    task automatic send_word(input string tag, input logic [15:0] w, input bit bp,
                             input bit hold, input logic [15:0] nxt);
        int k;
        int cyc;
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        if (hold) in_data = nxt;
        else      in_valid = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < 16 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            ser_ready = bp ? ((cyc % 3) == 1) : 1'b1;
            chk({tag, " l_ser_valid"}, 32'(l_ser_valid), 32'd1);
            chk({tag, " m_ser_valid"}, 32'(m_ser_valid), 32'd1);
            chk({tag, " l_in_ready"},  32'(l_in_ready),  32'd0);
            chk({tag, " m_busy"},      32'(m_busy),      32'd1);
            chk({tag, " l_ser_out"},   32'(l_ser_out),   32'(w[k]));
            chk({tag, " m_ser_out"},   32'(m_ser_out),   32'(w[15-k]));
            chk({tag, " l_ser_last"},  32'(l_ser_last),  32'(k == 15));
            chk({tag, " m_ser_last"},  32'(m_ser_last),  32'(k == 15));
            if (ser_ready) k++;
        end
        chk({tag, " beats"}, 32'(k), 32'd16);
        if (!bp) chk({tag, " shift_cycles"}, 32'(cyc), 32'd16);
        exp_cnt = exp_cnt + 8'd1;
        @(negedge clk);
        ser_ready = 1'b1;
        chk_idle(tag);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_cnt   = 8'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        ser_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset l_ser_out", 32'(l_ser_out), 32'd0);
        chk("reset m_ser_out", 32'(m_ser_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("after_reset");

        // Reset mid-word after 5 accepted beats of 16'hFFFF
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst l_ser_valid", 32'(l_ser_valid), 32'd0);
        chk("midrst m_ser_valid", 32'(m_ser_valid), 32'd0);
        chk("midrst l_busy",      32'(l_busy),      32'd0);
        chk("midrst l_word_cnt",  32'(l_word_cnt),  32'd0);
        chk("midrst l_ser_out",   32'(l_ser_out),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("midrst_release");

        send_word("lsb_0F0F", 16'h0F0F, 1'b0, 1'b0, 16'h0000);
        send_word("msb_8001", 16'h8001, 1'b0, 1'b0, 16'h0000);
        send_word("bp_A5A5",  16'hA5A5, 1'b1, 1'b0, 16'h0000);
        send_word("block_1",  16'h1234, 1'b0, 1'b1, 16'hC3E7);
        send_word("block_2",  16'hC3E7, 1'b0, 1'b0, 16'h0000);

        for (int i = 0; i < 251; i++) begin
            send_word("wrap", 16'($urandom), 1'b0, 1'b0, 16'h0000);
        end
        chk("wrap l_word_cnt_zero", 32'(l_word_cnt), 32'd0);
        chk("wrap m_word_cnt_zero", 32'(m_word_cnt), 32'd0);
        send_word("post_wrap", 16'h8000, 1'b0, 1'b0, 16'h0000);
        chk("post_wrap l_word_cnt", 32'(l_word_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_serializer
`default_nettype wire
